// File: rtl/branch_controller.sv
// Conditional branch resolver: accepts a branch from decode, evaluates it on
// latched operands, and on a taken branch pulses a PC redirect and holds
// flush for FLUSH_CYCLES cycles while stalling the front end.
module branch_controller #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             brValid,
  output logic             brReady,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [WIDTH-1:0] pcCurrent,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pcOut,
  output logic             pcLoad,
  output logic             flush,
  output logic             stall,
  output logic             taken,
  output logic [7:0]       takenCount
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DRAIN_LOAD = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [WIDTH-1:0] ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [2:0]         opReg;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [WIDTH-1:0]   pcReg;
  logic [WIDTH-1:0]   immReg;
  logic [CNT_W-1:0]   drainCnt;
  logic [CNT_W-1:0]   drainCntNext;
  logic               handshake;
  logic               cond;
  logic [WIDTH-1:0]   target;

  // Accept only real branch opcodes, and only while idle
  assign handshake = brValid && (state == IDLE) && opCode[3];

  // Redirect target wraps modulo 2^WIDTH
  assign target = WIDTH'(pcReg + immReg);

  // Signed branch condition on the latched operands
  always_comb begin
    cond = 1'b0;
    case (opReg)
      3'b000:  cond = $signed(bReg) >  $signed(aReg);
      3'b001:  cond = $signed(bReg) >  $signed(ZERO);
      3'b010:  cond = $signed(bReg) <  $signed(aReg);
      3'b011:  cond = $signed(bReg) <  $signed(ZERO);
      3'b100:  cond = bReg == aReg;
      3'b101:  cond = bReg == ZERO;
      3'b110:  cond = bReg != aReg;
      default: cond = bReg != ZERO;
    endcase
  end

  // Next-state and drain-counter decode
  always_comb begin
    nextState    = state;
    drainCntNext = drainCnt;
    case (state)
      IDLE: begin
        if (handshake) nextState = EVAL;
      end
      EVAL: begin
        nextState = cond ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          nextState    = DRAIN;
          drainCntNext = CNT_W'(DRAIN_LOAD);
        end else begin
          nextState = IDLE;
        end
      end
      DRAIN: begin
        if (drainCnt == '0) nextState = IDLE;
        else                drainCntNext = CNT_W'(drainCnt - 1'b1);
      end
      default: nextState = IDLE;
    endcase
  end

  // State register; outputs registered from the next-state decode so they
  // line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drainCnt   <= '0;
      opReg      <= '0;
      aReg       <= '0;
      bReg       <= '0;
      pcReg      <= '0;
      immReg     <= '0;
      brReady    <= 1'b1;
      stall      <= 1'b0;
      pcLoad     <= 1'b0;
      flush      <= 1'b0;
      pcOut      <= '0;
      taken      <= 1'b0;
      takenCount <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= drainCntNext;
      brReady  <= (nextState == IDLE);
      stall    <= (nextState != IDLE);
      pcLoad   <= (nextState == REDIRECT);
      flush    <= (nextState == REDIRECT) || (nextState == DRAIN);
      if (handshake) begin
        opReg  <= opCode[2:0];
        aReg   <= BusA;
        bReg   <= BusB;
        pcReg  <= pcCurrent;
        immReg <= imm;
      end
      if (nextState == REDIRECT) pcOut <= target;
      if (state == EVAL) begin
        taken <= cond;
        if (cond) takenCount <= 8'(takenCount + 8'd1);
      end
    end
  end

endmodule

// File: doc/branch_controller.md
BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 Parameter WIDTH, default 16, datapath and PC width.
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush is held per taken branch; legal range 1..15.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 brValid  input  1  decode presents a candidate branch this cycle.
REQ-007 brReady  output  1  controller can accept a branch.
REQ-008 opCode  input  4  instruction opcode.
REQ-009 BusA  input  WIDTH  first operand, signed two's complement.
REQ-010 BusB  input  WIDTH  second operand, signed two's complement.
REQ-011 pcCurrent  input  WIDTH  PC of the branch instruction.
REQ-012 imm  input  WIDTH  sign-extended branch offset.
REQ-013 pcOut  output  WIDTH  redirect target; holds its last value when pcLoad=0.
REQ-014 pcLoad  output  1  one-cycle pulse that loads pcOut into the PC.
REQ-015 flush  output  1  squash the fetch/decode stages.
REQ-016 stall  output  1  freeze the front end while a branch is resolving.
REQ-017 taken  output  1  registered outcome of the last evaluated branch.
REQ-018 takenCount  output  8  count of taken branches, wraps 255->0.

Function
REQ-019 A handshake SHALL occur at an edge where brValid=1, brReady=1, opCode[3]=1 and reset=0.
- On a handshake, latch opCode, BusA, BusB, pcCurrent and imm.
- brValid with opCode[3]=0 SHALL be ignored.
REQ-020 The FSM states SHALL be IDLE, EVAL, REDIRECT and DRAIN.
- IDLE->EVAL on handshake.
- EVAL->REDIRECT if the condition is true, otherwise EVAL->IDLE.
- REDIRECT->DRAIN if FLUSH_CYCLES>1, otherwise REDIRECT->IDLE.
- DRAIN->IDLE after FLUSH_CYCLES-1 cycles.
REQ-021 brReady SHALL equal (state==IDLE), and stall SHALL equal (state!=IDLE).
- brValid is ignored in any non-IDLE state.
REQ-022 The condition SHALL be evaluated in EVAL on latched values, using a signed compare.
- 1000 BGT: BusB>BusA.
- 1001 BGTZ: BusB>0.
- 1010 BLT: BusB<BusA.
- 1011 BLTZ: BusB<0.
- 1100 BEQ: BusB==BusA.
- 1101 BEQZ: BusB==0.
- 1110 BNE: BusB!=BusA.
- 1111 BNEZ: BusB!=0.
- The Z variants ignore BusA.
REQ-023 The target SHALL be pcCurrent+imm modulo 2^WIDTH, with no overflow flag.
REQ-024 taken SHALL update at the EVAL exit edge, and takenCount SHALL increment at the same edge when the condition is true.
REQ-025 In REDIRECT, for exactly one cycle, pcLoad=1 and pcOut=target.
- flush SHALL be 1 throughout REDIRECT and DRAIN: FLUSH_CYCLES cycles total.
REQ-026 Latency, with the handshake at edge T:
- EVAL occupies cycle T+1.
- If taken: pcLoad is in cycle T+2, and brReady returns in cycle T+2+FLUSH_CYCLES.
- If not taken: IDLE in cycle T+2, with no pcLoad and no flush.
REQ-027 Back-to-back branches SHALL be accepted in the first IDLE cycle after a previous branch completes.

Reset
REQ-028 While reset=1 at an edge:
- The state SHALL go to IDLE.
- pcOut, pcLoad, flush, stall, taken and takenCount SHALL all be 0.
- brReady SHALL be 1.
REQ-029 Reset SHALL take priority over brValid and over any in-flight state.
- A pending REDIRECT is cancelled, and no pcLoad is emitted.

Verification
REQ-030 Reset: hold reset 2 cycles -> all outputs 0, brReady=1.
REQ-031 BGT taken, with FLUSH_CYCLES=2: BusA=10, BusB=20, opCode=1000, pcCurrent=0x0040, imm=0x0008 -> stall for 3 cycles.
- pcLoad pulse with pcOut=0x0048.
- flush for 2 cycles.
- taken=1, takenCount=1.
- brReady=1 four cycles after the handshake.
REQ-032 BLTZ with signed operands and PC wrap: BusB=0xFFFB, opCode=1011, pcCurrent=0x0002, imm=0xFFFC -> taken, pcOut=0xFFFE.
REQ-033 BEQ not taken: BusA=10, BusB=20, opCode=1100 -> stall for 1 cycle, no pcLoad, no flush, taken=0, takenCount unchanged.
REQ-034 Ignored requests: brValid with opCode=0011 -> no state change, brReady stays 1.
- brValid held high during EVAL or DRAIN -> no second capture.
REQ-035 Reset during a branch: reset=1 in the REDIRECT cycle -> next cycle pcLoad=0, flush=0, stall=0, takenCount=0.
